// File: rtl/secded16_enc_pipe.sv
// SEC-DED (22,16) encoder, two-stage valid/ready pipeline with error injection.
// Ports: clk, rst (sync, high), in_valid/in_ready/in_data/inj_mask -> out_valid/out_ready/out_data/out_chk, word_cnt.
module secded16_enc_pipe #(
  parameter int CNT_W  = 16,
  parameter bit INJ_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_data,
  input  logic [21:0]      inj_mask,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_data,
  output logic [5:0]       out_chk,
  output logic [CNT_W-1:0] word_cnt
);

  // Each mask selects the Hamming positions whose index has bit k set.
  localparam logic [21:0] M0 = 22'h2AAAAA;
  localparam logic [21:0] M1 = 22'h0CCCCC;
  localparam logic [21:0] M2 = 22'h30F0F0;
  localparam logic [21:0] M3 = 22'h00FF00;
  localparam logic [21:0] M4 = 22'h3F0000;

  logic        a_vld;
  logic [15:0] a_data;
  logic [21:0] a_mask;
  logic        b_vld;
  logic [21:0] b_code;

  logic        b_take;
  logic        in_xfer;
  logic [21:0] pos_vec;
  logic [5:0]  chk;
  logic [21:0] code;

  assign b_take   = !b_vld || out_ready;
  assign in_ready = !a_vld || b_take;
  assign in_xfer  = in_valid && in_ready;

  // Data laid out on positions 1..21; power-of-two slots and slot 0 are 0.
  assign pos_vec = {a_data[15:11], 1'b0,
                    a_data[10:4],  1'b0,
                    a_data[3:1],   1'b0,
                    a_data[0],     3'b000};

  always_comb begin
    chk    = '0;
    chk[0] = ^(pos_vec & M0);
    chk[1] = ^(pos_vec & M1);
    chk[2] = ^(pos_vec & M2);
    chk[3] = ^(pos_vec & M3);
    chk[4] = ^(pos_vec & M4);
    chk[5] = (^a_data) ^ (^chk[4:0]);
  end

  assign code = {chk, a_data} ^ a_mask;

  always_ff @(posedge clk) begin
    if (rst) begin
      a_vld  <= 1'b0;
      a_data <= '0;
      a_mask <= '0;
    end else if (in_xfer) begin
      a_vld  <= 1'b1;
      a_data <= in_data;
      a_mask <= INJ_EN ? inj_mask : '0;
    end else if (b_take) begin
      a_vld <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      b_vld  <= 1'b0;
      b_code <= '0;
    end else if (b_take) begin
      b_vld <= a_vld;
      if (a_vld) begin
        b_code <= code;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      word_cnt <= '0;
    end else if (b_vld && out_ready) begin
      word_cnt <= word_cnt + 1'b1;
    end
  end

  assign out_valid = b_vld;
  assign out_data  = b_code[15:0];
  assign out_chk   = b_code[21:16];

endmodule
